// File: rtl/uart_receiver_if.sv
// Receive-side bundle of the UART receiver.
//   serial_in     : asynchronous UART line, idle high (driven by line/master)
//   parity_type   : 0 none, 1 odd, 2 even, 3 none (driven by master)
//   data_out      : last received byte
//   data_valid    : one-cycle strobe per completed frame
//   parity_error  : parity mismatch on last frame, held until next frame
//   framing_error : stop bit sampled low on last frame, held until next frame
//   busy          : receiver is inside a frame
interface uart_receiver_if;
    logic       serial_in;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;
    logic       busy;

    modport master (
        output serial_in,
        output parity_type,
        input  data_out,
        input  data_valid,
        input  parity_error,
        input  framing_error,
        input  busy
    );

    modport slave (
        input  serial_in,
        input  parity_type,
        output data_out,
        output data_valid,
        output parity_error,
        output framing_error,
        output busy
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: 1 start, 8 data bits LSB first, optional parity, 1 stop.
// The line is oversampled by the system clock and each bit is sampled at
// mid-bit, timed from the detected start edge.
//   clk          : system clock, rising edge
//   one_shot_rst : asynchronous, active-high reset
//   rx           : slave side of uart_receiver_if (line in, byte/flags out)
module uart_receiver #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115_200
) (
    input  logic           clk,
    input  logic           one_shot_rst,
    uart_receiver_if.slave rx
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_e;

    rx_state_e        state_q;
    logic             sync1_q;
    logic             rx_s_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [1:0]       parity_q;
    logic             parity_err_q;
    logic [7:0]       data_out_q;
    logic             data_valid_q;
    logic             parity_error_q;
    logic             framing_error_q;
    logic             busy_q;

    // Parity mode as latched at start detection; code 3 behaves as none.
    logic [1:0] parity_sel_d;
    // Parity bit the transmitter should have sent for the byte in shift_q.
    logic       parity_exp_d;
    logic       half_done_d;
    logic       bit_done_d;

    assign parity_sel_d = (rx.parity_type == 2'd3) ? PAR_NONE : rx.parity_type;
    assign parity_exp_d = (parity_q == PAR_ODD) ? ~^shift_q : ^shift_q;
    assign half_done_d  = (clk_cnt_q == CNT_W'(HALF_BIT - 1));
    assign bit_done_d   = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Two-flop synchronizer; every decision below looks at rx_s_q only.
    always_ff @(posedge clk or posedge one_shot_rst) begin
        if (one_shot_rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx.serial_in;
            rx_s_q  <= sync1_q;
        end
    end

    // Receive FSM with registered outputs.
    always_ff @(posedge clk or posedge one_shot_rst) begin
        if (one_shot_rst) begin
            state_q         <= RX_IDLE;
            clk_cnt_q       <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            parity_q        <= PAR_NONE;
            parity_err_q    <= 1'b0;
            data_out_q      <= '0;
            data_valid_q    <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    busy_q    <= 1'b0;
                    clk_cnt_q <= '0;
                    bit_idx_q <= '0;
                    if (!rx_s_q) begin
                        parity_q <= parity_sel_d;
                        busy_q   <= 1'b1;
                        state_q  <= RX_START;
                    end
                end
                RX_START: begin
                    if (half_done_d) begin
                        clk_cnt_q <= '0;
                        if (!rx_s_q) begin
                            state_q <= RX_DATA;
                        end else begin
                            // Line went back high before mid-start: glitch.
                            busy_q  <= 1'b0;
                            state_q <= RX_IDLE;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (bit_done_d) begin
                        clk_cnt_q          <= '0;
                        shift_q[bit_idx_q] <= rx_s_q;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q    <= '0;
                            parity_err_q <= 1'b0;
                            state_q      <= (parity_q != PAR_NONE) ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                RX_PARITY: begin
                    if (bit_done_d) begin
                        clk_cnt_q    <= '0;
                        parity_err_q <= rx_s_q ^ parity_exp_d;
                        state_q      <= RX_STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (bit_done_d) begin
                        clk_cnt_q       <= '0;
                        data_out_q      <= shift_q;
                        data_valid_q    <= 1'b1;
                        parity_error_q  <= parity_err_q;
                        framing_error_q <= ~rx_s_q;
                        // Leaving at mid-stop lets a back-to-back start edge be caught.
                        if (rx_s_q) begin
                            busy_q  <= 1'b0;
                            state_q <= RX_IDLE;
                        end else begin
                            state_q <= RX_WAIT_HIGH;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                RX_WAIT_HIGH: begin
                    // A held-low (break) line must not start new frames.
                    busy_q <= 1'b1;
                    if (rx_s_q) begin
                        busy_q  <= 1'b0;
                        state_q <= RX_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= RX_IDLE;
                end
            endcase
        end
    end

    assign rx.data_out      = data_out_q;
    assign rx.data_valid    = data_valid_q;
    assign rx.parity_error  = parity_error_q;
    assign rx.framing_error = framing_error_q;
    assign rx.busy          = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: a bit-banged transmitter drives the
// line, expected frames go into a scoreboard queue, and a monitor compares
// each data_valid strobe against the head of that queue.
module tb_uart_receiver;

    localparam int unsigned CPB  = 434;
    localparam int unsigned HALF = 217;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       busy;
    } exp_t;

    logic clk;
    logic one_shot_rst;

    uart_receiver_if u_if ();

    uart_receiver #(
        .CLK_FREQ  (50_000_000),
        .BAUD_RATE (115_200)
    ) dut (
        .clk          (clk),
        .one_shot_rst (one_shot_rst),
        .rx           (u_if)
    );

    exp_t       sb_q[$];
    int         checks;
    int         errors;
    int         dv_count;
    logic [7:0] last_data;
    logic       last_perr;
    logic       last_ferr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every strobe must match the oldest pending frame.
    always @(negedge clk) begin
        exp_t e;
        if (u_if.data_valid === 1'b1) begin
            dv_count++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dv data_out=%h required no strobe", u_if.data_out);
            end else begin
                e = sb_q.pop_front();
                if (u_if.data_out !== e.data) begin
                    errors++;
                    $display("FAIL dv_data got=%h exp=%h", u_if.data_out, e.data);
                end
                checks++;
                if (u_if.parity_error !== e.perr) begin
                    errors++;
                    $display("FAIL dv_parity_error got=%b exp=%b data=%h", u_if.parity_error, e.perr, e.data);
                end
                checks++;
                if (u_if.framing_error !== e.ferr) begin
                    errors++;
                    $display("FAIL dv_framing_error got=%b exp=%b data=%h", u_if.framing_error, e.ferr, e.data);
                end
                checks++;
                if (u_if.busy !== e.busy) begin
                    errors++;
                    $display("FAIL dv_busy got=%b exp=%b data=%h", u_if.busy, e.busy, e.data);
                end
                last_data = e.data;
                last_perr = e.perr;
                last_ferr = e.ferr;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic bit_time(input logic v);
        u_if.serial_in = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic [1:0] pt, input logic has_par,
                              input logic par_bit, input logic stop_bit);
        u_if.parity_type = pt;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        if (has_par) bit_time(par_bit);
        bit_time(stop_bit);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        one_shot_rst     = 1'b1;
        u_if.serial_in   = 1'b1;
        u_if.parity_type = 2'd0;
        repeat (5) @(negedge clk);
        checks++;
        if (u_if.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got=%h exp=00", u_if.data_out); end
        checks++;
        if (u_if.data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got=%b exp=0", u_if.data_valid); end
        checks++;
        if (u_if.parity_error !== 1'b0) begin errors++; $display("FAIL reset_parity_error got=%b exp=0", u_if.parity_error); end
        checks++;
        if (u_if.framing_error !== 1'b0) begin errors++; $display("FAIL reset_framing_error got=%b exp=0", u_if.framing_error); end
        checks++;
        if (u_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", u_if.busy); end
        one_shot_rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_no_parity();
        sb_q.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0, busy: 1'b0});
        send_frame(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1);
        wait_drain("no_parity");
        // Code 3 behaves as no parity: no parity bit on the line.
        sb_q.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0, busy: 1'b0});
        send_frame(8'h5A, 2'd3, 1'b0, 1'b0, 1'b1);
        wait_drain("parity3_none");
    endtask

    task automatic test_parity();
        // 0x3C has four ones: odd parity bit is 1, even parity bit is 0.
        sb_q.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0, busy: 1'b0});
        send_frame(8'h3C, 2'd1, 1'b1, 1'b1, 1'b1);
        wait_drain("odd_ok");
        sb_q.push_back('{data: 8'h3C, perr: 1'b1, ferr: 1'b0, busy: 1'b0});
        send_frame(8'h3C, 2'd2, 1'b1, 1'b1, 1'b1);
        wait_drain("even_bad");
    endtask

    task automatic test_framing();
        int n;
        sb_q.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b1, busy: 1'b1});
        send_frame(8'h55, 2'd0, 1'b0, 1'b0, 1'b0);
        n = dv_count;
        repeat (20 * CPB) @(negedge clk);
        wait_drain("framing");
        checks++;
        if (u_if.busy !== 1'b1) begin errors++; $display("FAIL break_busy got=%b exp=1", u_if.busy); end
        u_if.serial_in = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (u_if.busy !== 1'b0) begin errors++; $display("FAIL break_release_busy got=%b exp=0", u_if.busy); end
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (dv_count !== n) begin errors++; $display("FAIL break_extra_frames got=%0d exp=%0d", dv_count, n); end
    endtask

    task automatic test_glitch();
        int n;
        int t;
        n = dv_count;
        u_if.serial_in = 1'b0;
        repeat (100) @(negedge clk);
        u_if.serial_in = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (u_if.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy got=%b exp=1", u_if.busy); end
        t = 150;
        while (u_if.busy === 1'b1 && t < 600) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t < HALF - 2 || t > HALF + 8) begin
            errors++;
            $display("FAIL glitch_return_cycle got=%0d exp=%0d..%0d", t, HALF - 2, HALF + 8);
        end
        repeat (CPB) @(negedge clk);
        checks++;
        if (dv_count !== n) begin errors++; $display("FAIL glitch_dv got=%0d exp=%0d", dv_count, n); end
        checks++;
        if (u_if.parity_error !== last_perr || u_if.framing_error !== last_ferr || u_if.data_out !== last_data) begin
            errors++;
            $display("FAIL glitch_flags got=%b%b/%h exp=%b%b/%h", u_if.parity_error, u_if.framing_error,
                     u_if.data_out, last_perr, last_ferr, last_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int n;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h81;
        n = dv_count;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{data: bytes[i], perr: 1'b0, ferr: 1'b0, busy: 1'b0});
            send_frame(bytes[i], 2'd2, 1'b1, ^bytes[i], 1'b1);
        end
        wait_drain("back_to_back");
        checks++;
        if (dv_count !== n + 3) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", dv_count, n + 3); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        int n;
        b = 8'hC3;
        n = dv_count;
        u_if.parity_type = 2'd0;
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(b[i]);
        u_if.serial_in = b[4];
        repeat (CPB / 2) @(negedge clk);
        checks++;
        if (u_if.busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got=%b exp=1", u_if.busy); end
        one_shot_rst = 1'b1;
        #1;
        checks++;
        if (u_if.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", u_if.busy); end
        checks++;
        if (u_if.data_out !== 8'h00) begin errors++; $display("FAIL rst_mid_data_out got=%h exp=00", u_if.data_out); end
        repeat (3) @(negedge clk);
        one_shot_rst   = 1'b0;
        u_if.serial_in = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (dv_count !== n) begin errors++; $display("FAIL rst_mid_dv got=%0d exp=%0d", dv_count, n); end
        sb_q.push_back('{data: 8'h7E, perr: 1'b0, ferr: 1'b0, busy: 1'b0});
        send_frame(8'h7E, 2'd0, 1'b0, 1'b0, 1'b1);
        wait_drain("after_reset");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        dv_count  = 0;
        last_data = 8'h00;
        last_perr = 1'b0;
        last_ferr = 1'b0;
        test_reset();
        test_no_parity();
        test_parity();
        test_framing();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
